// File: rtl/bound_relu_pkg.sv
// Shared widths, bound-select encodings and the bound helper for the
// three-lane bounded-ReLU activation stage.
package bound_relu_pkg;

  localparam int D_BW_DEF  = 8;
  localparam int AB_BW_DEF = 21;

  localparam logic [1:0] SEL_B0 = 2'b00;  // 2^(D_BW-1) - 1
  localparam logic [1:0] SEL_B1 = 2'b01;  // 2^(D_BW-2) - 1
  localparam logic [1:0] SEL_B2 = 2'b10;  // 2^(D_BW-3) - 1
  localparam logic [1:0] SEL_B3 = 2'b11;  // 2^(D_BW-4) - 1

  // Upper bound for a select code: 2^(d_bw-1-sel) - 1.
  function automatic int unsigned bound_of(input logic [1:0] sel, input int d_bw);
    int unsigned sh;
    sh = unsigned'(d_bw - 1) - {30'd0, sel};
    return (32'd1 << sh) - 32'd1;
  endfunction

endpackage

// File: rtl/bound_relu_if.sv
// Bundle of the control and three-lane data signals of the activation stage.
// No handshake: every cycle carries one triple, sampled at the rising edge.
interface bound_relu_if #(
  parameter int D_BW  = 8,
  parameter int AB_BW = 21
);
  logic                    bound_en;
  logic [1:0]              i_bound_sel;
  logic signed [AB_BW-1:0] i_acc_bias0;
  logic signed [AB_BW-1:0] i_acc_bias1;
  logic signed [AB_BW-1:0] i_acc_bias2;
  logic signed [D_BW-1:0]  o_act_data0;
  logic signed [D_BW-1:0]  o_act_data1;
  logic signed [D_BW-1:0]  o_act_data2;

  modport master (
    output bound_en, i_bound_sel, i_acc_bias0, i_acc_bias1, i_acc_bias2,
    input  o_act_data0, o_act_data1, o_act_data2
  );

  modport slave (
    input  bound_en, i_bound_sel, i_acc_bias0, i_acc_bias1, i_acc_bias2,
    output o_act_data0, o_act_data1, o_act_data2
  );
endinterface

// File: rtl/bound_relu_lane.sv
// One activation lane: full-width clamp to [0, bound] followed by the
// output register.
module bound_relu_lane #(
  parameter int D_BW  = 8,
  parameter int AB_BW = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [AB_BW-1:0] acc_bias,
  input  logic signed [AB_BW-1:0] bound,
  output logic signed [D_BW-1:0]  act_data
);

  logic signed [D_BW-1:0] clamped;

  // Compare at full input width so large magnitudes never wrap.
  always_comb begin
    clamped = '0;
    if (acc_bias < 0) begin
      clamped = '0;
    end else if (acc_bias > bound) begin
      clamped = bound[D_BW-1:0];
    end else begin
      clamped = acc_bias[D_BW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_data <= '0;
    end else begin
      act_data <= clamped;
    end
  end

endmodule

// File: rtl/bound_relu_top.sv
// Three-lane bounded-ReLU stage: decodes the shared bound once and fans it
// out to three identical registered clamp lanes (latency 1).
module bound_relu_top
  import bound_relu_pkg::*;
#(
  parameter int D_BW  = D_BW_DEF,
  parameter int AB_BW = AB_BW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  bound_relu_if.slave bus
);

  logic signed [AB_BW-1:0] eff_bound;

  // Without bound_en the stage is a plain saturating ReLU at the max code.
  always_comb begin
    eff_bound = '0;
    if (bus.bound_en) begin
      eff_bound = AB_BW'(bound_of(bus.i_bound_sel, D_BW));
    end else begin
      eff_bound = AB_BW'(bound_of(SEL_B0, D_BW));
    end
  end

  bound_relu_lane #(.D_BW(D_BW), .AB_BW(AB_BW)) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .acc_bias (bus.i_acc_bias0),
    .bound    (eff_bound),
    .act_data (bus.o_act_data0)
  );

  bound_relu_lane #(.D_BW(D_BW), .AB_BW(AB_BW)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .acc_bias (bus.i_acc_bias1),
    .bound    (eff_bound),
    .act_data (bus.o_act_data1)
  );

  bound_relu_lane #(.D_BW(D_BW), .AB_BW(AB_BW)) u_lane2 (
    .clk      (clk),
    .rst      (rst),
    .acc_bias (bus.i_acc_bias2),
    .bound    (eff_bound),
    .act_data (bus.o_act_data2)
  );

endmodule

// File: tb/tb_bound_relu_top.sv
// Self-checking bench for bound_relu_top: directed steps followed by random
// triples, each compared against an arithmetic reference of the clamp rule.
module tb_bound_relu_top;

  localparam int D_BW  = 8;
  localparam int AB_BW = 21;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [3*D_BW-1:0] exp_q[$];

  bound_relu_if #(.D_BW(D_BW), .AB_BW(AB_BW)) bus ();

  bound_relu_top #(.D_BW(D_BW), .AB_BW(AB_BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: clamp x into [0, bound] with plain integer arithmetic
  function automatic logic [D_BW-1:0] ref_act(input int x, input bit en,
                                              input int sel, input bit r);
    int b;
    int y;
    b = en ? (2 ** (D_BW - 1 - sel)) - 1 : (2 ** (D_BW - 1)) - 1;
    if (r)          y = 0;
    else if (x < 0) y = 0;
    else if (x > b) y = b;
    else            y = x;
    return D_BW'(y);
  endfunction

  task automatic check_lane(input string tag, input logic [D_BW-1:0] obs,
                            input logic [D_BW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // driver: present one triple at negedge, check it #1 after the next posedge
  task automatic step(input string tag, input bit r, input bit en, input int sel,
                      input int a0, input int a1, input int a2);
    logic [3*D_BW-1:0] e;
    @(negedge clk);
    rst             = r;
    bus.bound_en    = en;
    bus.i_bound_sel = 2'(sel);
    bus.i_acc_bias0 = AB_BW'(a0);
    bus.i_acc_bias1 = AB_BW'(a1);
    bus.i_acc_bias2 = AB_BW'(a2);
    exp_q.push_back({ref_act(a2, en, sel, r), ref_act(a1, en, sel, r),
                     ref_act(a0, en, sel, r)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_lane({tag, "/lane0"}, bus.o_act_data0, e[D_BW-1:0]);
    check_lane({tag, "/lane1"}, bus.o_act_data1, e[2*D_BW-1:D_BW]);
    check_lane({tag, "/lane2"}, bus.o_act_data2, e[3*D_BW-1:2*D_BW]);
  endtask

  function automatic int rand_val(input int k);
    case (k % 3)
      0:       return int'($urandom_range(0, 600)) - 300;
      1:       return int'($urandom_range(0, 2 ** AB_BW - 1)) - 2 ** (AB_BW - 1);
      default: return int'($urandom_range(0, 140));
    endcase
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.bound_en = 1'b1;
    bus.i_bound_sel = 2'b00;
    bus.i_acc_bias0 = '0;
    bus.i_acc_bias1 = '0;
    bus.i_acc_bias2 = '0;

    // reset with nonzero inputs, then first edge after release
    step("rst_a", 1, 1, 0, 100, 50, 25);
    step("rst_b", 1, 1, 0, 90, 60, 70);
    step("rel",   0, 1, 0, 90, 60, 70);

    step("s0_a", 0, 1, 0, 32, -190, 120);
    step("s0_b", 0, 1, 0, 200, -1048576, 127);
    step("s1_a", 0, 1, 1, 20, -33, 70);
    step("s1_b", 0, 1, 1, -10, 67, 30);
    step("s2_a", 0, 1, 2, -17, -33, 31);
    step("s2_b", 0, 1, 2, -6, 20, 40);
    step("s3_a", 0, 1, 3, -17, -11, 5);
    step("s3_b", 0, 1, 3, -1, 0, 30);
    step("s3_max", 0, 1, 3, 1048575, 16, 15);
    step("noen", 0, 0, 3, 100, 16, -5);
    step("noen_max", 0, 0, 2, 1048575, 128, 127);

    // select changes every cycle, applied to the data of the same edge
    for (int s = 0; s < 4; s++) step("tog", 0, 1, s, 50, 50, 50);

    // mid-stream reset discards the in-flight result
    step("mid_d",   0, 1, 0, 77, 88, 99);
    step("mid_rst", 1, 1, 0, 77, 88, 99);
    step("mid_rel", 0, 1, 1, 77, 88, 99);

    for (int k = 0; k < 300; k++) begin
      step("rnd", 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           rand_val(k), rand_val(k + 1), rand_val(k + 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
